mic_level_meter: RTL and testbench

- Downstream consumer of the mic ADC stage. Takes 12-bit unsigned mic samples and their one-cycle valid strobe.
- Removes the DC bias, tracks a decaying peak envelope, and reports a quantised loudness level once per sample window.
- The level drives the LED strip renderer. Fully pipelined; accepts a sample every cycle.

---
 rtl/mic_meter_pkg.sv | 16 +
 rtl/mic_dc_blocker.sv | 52 +++++
 rtl/mic_level_meter.sv | 156 +++++++++++++++
 tb/tb_mic_level_meter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_meter_pkg.sv
// Shared constants, sizing helpers and FSM state type for the mic level meter.
package mic_meter_pkg;

  localparam int unsigned DATA_W_DEF = 12;

  typedef enum logic {SETTLE, RUN} meter_state_t;

  function automatic int unsigned lvl_width(input int unsigned num_levels);
    return $clog2(num_levels + 1);
  endfunction

  function automatic int unsigned mid_scale(input int unsigned data_w);
    return 1 << (data_w - 1);
  endfunction

endpackage

// File: rtl/mic_dc_blocker.sv
// Stage 1 of the mic level meter: IIR DC tracker, bias-removed magnitude, clip detect.
module mic_dc_blocker
  import mic_meter_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DC_SHIFT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] mag,
  output logic              mag_valid,
  output logic              clip_hit
);

  localparam int unsigned       ACC_W = DATA_W + DC_SHIFT;
  localparam logic [DATA_W-1:0] MID   = DATA_W'(mid_scale(DATA_W));

  logic [ACC_W-1:0]       dc_acc;
  logic [ACC_W-1:0]       acc_nx;
  logic [DATA_W-1:0]      dc;
  logic signed [DATA_W:0] dev;
  logic [DATA_W:0]        dev_abs;
  logic [DATA_W-1:0]      mag_nx;

  // Subtracting dc before adding the sample keeps the sum inside ACC_W bits.
  always_comb begin
    dc      = dc_acc[ACC_W-1:DC_SHIFT];
    acc_nx  = dc_acc - {{DC_SHIFT{1'b0}}, dc} + {{DC_SHIFT{1'b0}}, sample_in};
    dev     = $signed({1'b0, sample_in}) - $signed({1'b0, dc});
    dev_abs = dev[DATA_W] ? $unsigned(-dev) : $unsigned(dev);
    mag_nx  = (dev_abs > {1'b0, MID}) ? MID : dev_abs[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dc_acc    <= {MID, {DC_SHIFT{1'b0}}};
      mag       <= '0;
      mag_valid <= 1'b0;
      clip_hit  <= 1'b0;
    end else begin
      mag_valid <= sample_valid;
      if (sample_valid) begin
        dc_acc   <= acc_nx;
        mag      <= mag_nx;
        clip_hit <= (sample_in == '0) || (sample_in == '1);
      end
    end
  end

endmodule

// File: rtl/mic_level_meter.sv
// Mic level meter: DC removal, decaying peak envelope, windowed loudness level.
// Define MIC_LEVEL_PEAK_HOLD_EN to build the peak-hold marker on peak_level.
module mic_level_meter
  import mic_meter_pkg::*;
#(
  parameter int unsigned  DATA_W       = DATA_W_DEF,
  parameter int unsigned  DC_SHIFT     = 8,
  parameter int unsigned  WIN_LOG2     = 10,
  parameter int unsigned  DECAY_STEP   = 16,
  parameter int unsigned  NUM_LEVELS   = 16,
  parameter int unsigned  SETTLE_WIN   = 4,
  parameter int unsigned  HOLD_WINDOWS = 8,
  localparam int unsigned LVL_W        = lvl_width(NUM_LEVELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [LVL_W-1:0]  level,
  output logic              level_valid,
  output logic [DATA_W-1:0] envelope,
  output logic              clip,
  output logic [LVL_W-1:0]  peak_level
);

  localparam int unsigned       PROD_W = DATA_W + LVL_W;
  localparam int unsigned       SET_W  = (SETTLE_WIN > 1) ? $clog2(SETTLE_WIN) : 1;
  localparam logic [DATA_W-1:0] DECAY  = DATA_W'(DECAY_STEP);
  localparam logic [LVL_W-1:0]  LVL_MAX = LVL_W'(NUM_LEVELS);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_WIN - 1);

  logic [DATA_W-1:0] mag;
  logic              mag_valid;
  logic              clip_hit;

  mic_dc_blocker #(
    .DATA_W   (DATA_W),
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_blocker (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .mag          (mag),
    .mag_valid    (mag_valid),
    .clip_hit     (clip_hit)
  );

  // Stage 2: envelope, window max, clip accumulation, window counter.
  logic [DATA_W-1:0]   env, env_nx, win_max, win_max_nx;
  logic [WIN_LOG2-1:0] win_cnt;
  logic                clip_acc, win_close, win_first;

  always_comb begin
    if (mag >= env)      env_nx = mag;
    else if (env > DECAY) env_nx = env - DECAY;
    else                 env_nx = '0;
    win_first  = (win_cnt == '0);
    win_max_nx = (win_first || (env_nx > win_max)) ? env_nx : win_max;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      env       <= '0;
      win_max   <= '0;
      win_cnt   <= '0;
      clip_acc  <= 1'b0;
      win_close <= 1'b0;
    end else begin
      win_close <= mag_valid && (win_cnt == '1);
      if (mag_valid) begin
        env      <= env_nx;
        win_max  <= win_max_nx;
        clip_acc <= win_first ? clip_hit : (clip_acc | clip_hit);
        win_cnt  <= win_cnt + WIN_LOG2'(1);
      end
    end
  end

  assign envelope = env;

  // Stage 3 reads the closed window's registers while stage 2 may already be
  // loading the next window's first sample in the same cycle.
  logic [PROD_W-1:0] lvl_prod, lvl_shift;
  logic [LVL_W-1:0]  lvl_raw, rep_level;
  logic              rep_clip;
  meter_state_t      state, state_nx;
  logic [SET_W-1:0]  settle_cnt, settle_nx;

  always_comb begin
    lvl_prod  = PROD_W'(win_max) * PROD_W'(NUM_LEVELS);
    lvl_shift = lvl_prod >> (DATA_W - 1);
    lvl_raw   = (lvl_shift > PROD_W'(NUM_LEVELS)) ? LVL_MAX : lvl_shift[LVL_W-1:0];
  end

  always_comb begin
    state_nx  = state;
    settle_nx = settle_cnt;
    rep_level = '0;
    rep_clip  = 1'b0;
    if (win_close && (state == SETTLE)) begin
      settle_nx = settle_cnt + SET_W'(1);
      if (settle_cnt == SETTLE_LAST) state_nx = RUN;
    end
    if (state == RUN) begin
      rep_level = lvl_raw;
      rep_clip  = clip_acc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SETTLE;
      settle_cnt  <= '0;
      level       <= '0;
      clip        <= 1'b0;
      level_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      settle_cnt  <= settle_nx;
      level_valid <= win_close;
      if (win_close) begin
        level <= rep_level;
        clip  <= rep_clip;
      end
    end
  end

`ifdef MIC_LEVEL_PEAK_HOLD_EN
  localparam int unsigned HOLD_W = $clog2(HOLD_WINDOWS + 1);
  logic [HOLD_W-1:0] hold_cnt;

  // In the decay branch lvl_raw < peak_level, so peak_level-1 never drops below it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_level <= '0;
      hold_cnt   <= '0;
    end else if (win_close) begin
      if (state == SETTLE) begin
        peak_level <= '0;
        hold_cnt   <= '0;
      end else if (lvl_raw >= peak_level) begin
        peak_level <= lvl_raw;
        hold_cnt   <= HOLD_W'(HOLD_WINDOWS);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end else begin
        peak_level <= peak_level - LVL_W'(1);
      end
    end
  end
`else
  assign peak_level = level;
`endif

endmodule

// File: tb/tb_mic_level_meter.sv
// Self-checking bench for mic_level_meter against a per-sample behavioural model.
module tb_mic_level_meter;

  localparam int DW     = 12;
  localparam int DCS    = 8;
  localparam int WLOG   = 10;
  localparam int WIN    = 1 << WLOG;
  localparam int DECAY  = 16;
  localparam int NL     = 16;
  localparam int SETTLE = 4;
  localparam int HOLD   = 8;
  localparam int MID    = 1 << (DW - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic [4:0]    level;
  logic          level_valid;
  logic [DW-1:0] envelope;
  logic          clip;
  logic [4:0]    peak_level;

  mic_level_meter #(
    .DATA_W       (DW),
    .DC_SHIFT     (DCS),
    .WIN_LOG2     (WLOG),
    .DECAY_STEP   (DECAY),
    .NUM_LEVELS   (NL),
    .SETTLE_WIN   (SETTLE),
    .HOLD_WINDOWS (HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .level        (level),
    .level_valid  (level_valid),
    .envelope     (envelope),
    .clip         (clip),
    .peak_level   (peak_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int lvl;
    int clp;
    int pk;
    int cyc;
  } rep_t;

  rep_t exp_q[$];
  int   exp_hist[$];
  int   obs_hist[$];

  // Reference model: plain integer arithmetic on the documented rules.
  int m_acc, m_env, m_cnt, m_wmax, m_wclip, m_settled, m_peak, m_hold;

  function automatic void model_reset();
    m_acc = MID * (1 << DCS);
    m_env = 0; m_cnt = 0; m_wmax = 0; m_wclip = 0;
    m_settled = 0; m_peak = 0; m_hold = 0;
  endfunction

  function automatic void model_sample(input int s, input int c);
    int   dc, mag, raw;
    rep_t r;
    dc    = m_acc / (1 << DCS);
    m_acc = m_acc + s - dc;
    mag   = s - dc;
    if (mag < 0) mag = -mag;
    if (mag > MID) mag = MID;
    if (mag >= m_env) m_env = mag;
    else m_env = (m_env > DECAY) ? m_env - DECAY : 0;
    if (m_cnt == 0) begin
      m_wmax = m_env; m_wclip = 0;
    end else if (m_env > m_wmax) m_wmax = m_env;
    if (s == 0 || s == (1 << DW) - 1) m_wclip = 1;
    m_cnt++;
    if (m_cnt == WIN) begin
      m_cnt = 0;
      raw = m_wmax * NL / MID;
      if (raw > NL) raw = NL;
      if (m_settled < SETTLE) begin
        r.lvl = 0; r.clp = 0; m_peak = 0; m_hold = 0;
        m_settled++;
      end else begin
        r.lvl = raw; r.clp = m_wclip;
`ifdef MIC_LEVEL_PEAK_HOLD_EN
        if (raw >= m_peak) begin
          m_peak = raw; m_hold = HOLD;
        end else if (m_hold > 0) m_hold--;
        else m_peak = (m_peak - 1 > raw) ? m_peak - 1 : raw;
`else
        m_peak = raw;
`endif
      end
      r.pk  = m_peak;
      r.cyc = c + 2;
      exp_q.push_back(r);
      exp_hist.push_back(r.lvl);
    end
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && level_valid === 1'b1) begin
      rep_t e;
      pulses++;
      obs_hist.push_back(int'(level));
      chk("pulse_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_level", level, e.lvl);
        chk("pulse_clip", clip, e.clp);
        chk("pulse_peak", peak_level, e.pk);
      end
    end
  end

  task automatic send(input int s);
    sample_in    = DW'(s);
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    model_sample(s, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_valid"}, level_valid, 0);
    chk({tag, "_env"}, envelope, 0);
    chk({tag, "_clip"}, clip, 0);
    chk({tag, "_peak"}, peak_level, 0);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b0;
    #1 reset_checks("async_rst");
    model_reset();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int pat[$];
  int hist_a[$];

  initial begin
    #1 rst = 1'b0;
    #12 reset_checks("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // Settling at mid-scale: four SETTLE reports then RUN.
    for (int i = 0; i < 6 * WIN; i++) send(2048);
    idle(4);
    chk("settle_pulses", pulses, 6);
    chk("settle_env", envelope, m_env);
    chk("settle_level", level, 0);
    chk("settle_clip", clip, 0);

    // Alternating +/-1024 around mid-scale.
    for (int i = 0; i < 2 * WIN; i++) send((i % 2 == 0) ? 1024 : 3072);
    idle(4);
    chk("alt_env", envelope, m_env);
    chk("alt_level_range", (level == 5'd7) || (level == 5'd8), 1);
    chk("alt_clip", clip, 0);

    // Full-scale alternation, then quiet window.
    for (int i = 0; i < WIN; i++) send((i % 2 == 0) ? 0 : 4095);
    idle(4);
    chk("rail_level", level, 16);
    chk("rail_clip", clip, 1);
    for (int i = 0; i < WIN; i++) send(2048);
    idle(4);
    chk("quiet_clip", clip, 0);
    chk("quiet_env", envelope, m_env);

    // Single spike then quiet windows; peak marker hold/decay.
    for (int i = 0; i < WIN; i++) send((i == 500) ? 4095 : 2048);
    for (int i = 0; i < 11 * WIN; i++) send(2048);
    idle(4);
    chk("spike_env", envelope, m_env);

    // Random windows.
    for (int i = 0; i < 2 * WIN; i++) send(int'($urandom_range(1200, 2900)));
    for (int i = 0; i < 300; i++) send(int'($urandom_range(600, 3500)));
    idle(4);
    chk("rand_env", envelope, m_env);

    // Reset in the middle of a window, then back-to-back vs gapped strobes.
    mid_reset();
    for (int i = 0; i < 5 * WIN; i++) pat.push_back(int'($urandom_range(300, 3800)));
    exp_hist.delete();
    foreach (pat[i]) send(pat[i]);
    idle(4);
    hist_a = exp_hist;
    mid_reset();
    obs_hist.delete();
    foreach (pat[i]) begin
      send(pat[i]);
      idle(4);
    end
    idle(4);
    chk("gap_count", obs_hist.size(), hist_a.size());
    for (int i = 0; i < hist_a.size() && i < obs_hist.size(); i++)
      chk("gap_level", obs_hist[i], hist_a[i]);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
